// File: rtl/rdma_cq_credit_tracker.sv
// rdma_cq_credit_tracker
// Tracks how many SQ requests each user region has in flight toward the
// network arbiter and retires them on completions from the CQ tap. A region
// that reaches its credit limit is backpressured until a completion frees a
// slot. Completion timeouts, underflows and bad vfids are latched as sticky
// error bits that host software clears with clr_err.

module rdma_cq_credit_tracker #(
    parameter int N_REGIONS       = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 5,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int TO_W            = 16,
    parameter int VFID_W          = 2
) (
    input  logic                       aclk,
    input  logic                       areset,

    input  logic [N_REGIONS-1:0]       s_sq_valid,
    output logic [N_REGIONS-1:0]       s_sq_ready,
    output logic [N_REGIONS-1:0]       m_sq_valid,
    input  logic [N_REGIONS-1:0]       m_sq_ready,

    input  logic                       s_cq_valid,
    input  logic [VFID_W-1:0]          s_cq_vfid,
    output logic                       s_cq_ready,

    input  logic                       clr_err,

    output logic [N_REGIONS*CNT_W-1:0] outstanding,
    output logic [N_REGIONS-1:0]       full,
    output logic                       idle,
    output logic [N_REGIONS-1:0]       err_underflow,
    output logic [N_REGIONS-1:0]       err_timeout,
    output logic                       err_vfid
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    // Per-region outstanding counts and completion-wait timers
    logic [CNT_W-1:0]     cnt_q [N_REGIONS];
    logic [CNT_W-1:0]     cnt_d [N_REGIONS];
    logic [TO_W-1:0]      to_q  [N_REGIONS];
    logic [TO_W-1:0]      to_d  [N_REGIONS];

    // Registered CQ tap
    logic                 cq_v_q;
    logic [VFID_W-1:0]    cq_id_q;

    // Per-cycle events
    logic [N_REGIONS-1:0] full_w;
    logic [N_REGIONS-1:0] fire;
    logic [N_REGIONS-1:0] dec;
    logic                 id_ok;
    logic [N_REGIONS-1:0] underflow_set;
    logic [N_REGIONS-1:0] timeout_set;
    logic                 vfid_set;

    // The completion tap is observe-only, so it can always accept
    assign s_cq_ready = 1'b1;

    // Full flags come straight from the registered counts
    always_comb begin
        full_w = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            full_w[i] = (cnt_q[i] == CNT_MAX);
        end
    end

    assign full = full_w;

    // Zero-latency SQ gate: a full region neither offers nor accepts
    always_comb begin
        m_sq_valid = '0;
        s_sq_ready = '0;
        fire       = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            m_sq_valid[i] = s_sq_valid[i] & ~full_w[i];
            s_sq_ready[i] = m_sq_ready[i] & ~full_w[i];
            fire[i]       = s_sq_valid[i] & m_sq_ready[i] & ~full_w[i];
        end
    end

    // Route the registered completion to its region; ids with no region are flagged
    always_comb begin
        dec   = '0;
        id_ok = 1'b0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (cq_id_q == VFID_W'(i)) begin
                id_ok  = 1'b1;
                dec[i] = cq_v_q;
            end
        end
        vfid_set = cq_v_q & ~id_ok;
    end

    // Next count: issue adds, completion retires, both together cancel out
    always_comb begin
        underflow_set = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({fire[i], dec[i]})
                2'b10: cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01: begin
                    if (cnt_q[i] == '0) begin
                        underflow_set[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Next timer: runs only while requests wait with no completion, saturating at the limit
    always_comb begin
        timeout_set = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            to_d[i] = to_q[i];
            if ((cnt_q[i] == '0) || dec[i]) begin
                to_d[i] = '0;
            end else if (to_q[i] != TO_LIMIT) begin
                to_d[i] = to_q[i] + TO_W'(1);
            end
            timeout_set[i] = (to_d[i] == TO_LIMIT);
        end
    end

    // Sample the CQ tap once so routing is off the input path
    always_ff @(posedge aclk) begin
        if (areset) begin
            cq_v_q  <= 1'b0;
            cq_id_q <= '0;
        end else begin
            cq_v_q  <= s_cq_valid;
            cq_id_q <= s_cq_vfid;
        end
    end

    // Outstanding counters and timers
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                cnt_q[i] <= '0;
                to_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                cnt_q[i] <= cnt_d[i];
                to_q[i]  <= to_d[i];
            end
        end
    end

    // Sticky error bits: clr_err wipes them, but a same-cycle set still lands
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_underflow <= '0;
            err_timeout   <= '0;
            err_vfid      <= 1'b0;
        end else begin
            err_underflow <= (clr_err ? '0 : err_underflow) | underflow_set;
            err_timeout   <= (clr_err ? '0 : err_timeout) | timeout_set;
            err_vfid      <= (clr_err ? 1'b0 : err_vfid) | vfid_set;
        end
    end

    // Flatten counts onto the packed status bus
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // Idle when no region has anything in flight
    always_comb begin
        idle = 1'b1;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (cnt_q[i] != '0) begin
                idle = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rdma_cq_credit_tracker.sv
// tb_rdma_cq_credit_tracker
// Directed bench: a table of per-cycle vectors for the basic count/gate path,
// then hand-written sequences for fill, cancel, underflow, timeout, bad vfid
// and reset. A second instance with three regions exercises the bad-vfid path.

module tb_rdma_cq_credit_tracker;

    logic        aclk = 1'b0;
    logic        areset;

    // Four-region instance with a short timeout
    logic [3:0]  s_sq_valid, s_sq_ready, m_sq_valid, m_sq_ready;
    logic        s_cq_valid, s_cq_ready, clr_err;
    logic [1:0]  s_cq_vfid;
    logic [19:0] outstanding;
    logic [3:0]  full, err_underflow, err_timeout;
    logic        idle, err_vfid;

    // Three-region instance
    logic [2:0]  b_s_sq_valid, b_s_sq_ready, b_m_sq_valid, b_m_sq_ready;
    logic        b_s_cq_valid, b_s_cq_ready, b_clr_err;
    logic [1:0]  b_s_cq_vfid;
    logic [14:0] b_outstanding;
    logic [2:0]  b_full, b_err_underflow, b_err_timeout;
    logic        b_idle, b_err_vfid;

    int numChecks = 0;
    int numFails  = 0;

    rdma_cq_credit_tracker #(
        .N_REGIONS(4), .MAX_OUTSTANDING(16), .CNT_W(5),
        .TIMEOUT_CYCLES(100), .TO_W(8), .VFID_W(2)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready),
        .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready),
        .s_cq_valid(s_cq_valid), .s_cq_vfid(s_cq_vfid), .s_cq_ready(s_cq_ready),
        .clr_err(clr_err), .outstanding(outstanding), .full(full), .idle(idle),
        .err_underflow(err_underflow), .err_timeout(err_timeout), .err_vfid(err_vfid)
    );

    rdma_cq_credit_tracker #(
        .N_REGIONS(3), .MAX_OUTSTANDING(16), .CNT_W(5),
        .TIMEOUT_CYCLES(100), .TO_W(8), .VFID_W(2)
    ) dut3 (
        .aclk(aclk), .areset(areset),
        .s_sq_valid(b_s_sq_valid), .s_sq_ready(b_s_sq_ready),
        .m_sq_valid(b_m_sq_valid), .m_sq_ready(b_m_sq_ready),
        .s_cq_valid(b_s_cq_valid), .s_cq_vfid(b_s_cq_vfid), .s_cq_ready(b_s_cq_ready),
        .clr_err(b_clr_err), .outstanding(b_outstanding), .full(b_full), .idle(b_idle),
        .err_underflow(b_err_underflow), .err_timeout(b_err_timeout), .err_vfid(b_err_vfid)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  sqv;
        logic [3:0]  rdy;
        logic        cqv;
        logic [1:0]  vid;
        logic        clr;
        logic [3:0]  expMv;
        logic [3:0]  expSr;
        logic [19:0] expCnt;
        logic [3:0]  expUf;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [19:0] cnts(int c0, int c1, int c2, int c3);
        return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    function automatic vec_t mkVec(logic [3:0] sqv, logic [3:0] rdy, logic cqv,
                                   logic [1:0] vid, logic clr, logic [3:0] mv,
                                   logic [3:0] sr, logic [19:0] cnt, logic [3:0] uf);
        vec_t v;
        v.sqv = sqv; v.rdy = rdy; v.cqv = cqv; v.vid = vid; v.clr = clr;
        v.expMv = mv; v.expSr = sr; v.expCnt = cnt; v.expUf = uf;
        return v;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        s_sq_valid = v.sqv;
        m_sq_ready = v.rdy;
        s_cq_valid = v.cqv;
        s_cq_vfid  = v.vid;
        clr_err    = v.clr;
    endtask

    task automatic clearInputs();
        s_sq_valid = '0; m_sq_ready = '0; s_cq_valid = 1'b0; s_cq_vfid = '0; clr_err = 1'b0;
        b_s_sq_valid = '0; b_m_sq_ready = '0; b_s_cq_valid = 1'b0; b_s_cq_vfid = '0;
        b_clr_err = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    initial begin
        int fires;
        clearInputs();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        #1;

        // Reset state
        checkOutput("rst_outstanding", 32'(outstanding), 0);
        checkOutput("rst_idle", 32'(idle), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_cq_ready", 32'(s_cq_ready), 1);
        checkOutput("rst_errors", 32'({err_underflow, err_timeout, err_vfid}), 0);

        // Table of per-cycle vectors starting from all-zero counts
        //                 sqv      rdy     cqv  vid   clr   m_sq_valid s_sq_ready counts after edge   uf
        vecs[0] = mkVec(4'b0011, 4'b0001, 0, 2'd0, 0, 4'b0011, 4'b0001, cnts(1,0,0,0), 4'b0000);
        vecs[1] = mkVec(4'b1111, 4'b1111, 1, 2'd0, 0, 4'b1111, 4'b1111, cnts(2,1,1,1), 4'b0000);
        vecs[2] = mkVec(4'b0000, 4'b1010, 1, 2'd2, 0, 4'b0000, 4'b1010, cnts(1,1,1,1), 4'b0000);
        vecs[3] = mkVec(4'b0100, 4'b0100, 0, 2'd0, 0, 4'b0100, 4'b0100, cnts(1,1,1,1), 4'b0000);
        vecs[4] = mkVec(4'b0000, 4'b0000, 1, 2'd3, 0, 4'b0000, 4'b0000, cnts(1,1,1,1), 4'b0000);
        vecs[5] = mkVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000, cnts(1,1,1,0), 4'b0000);
        vecs[6] = mkVec(4'b0000, 4'b0000, 1, 2'd3, 0, 4'b0000, 4'b0000, cnts(1,1,1,0), 4'b0000);
        vecs[7] = mkVec(4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000, cnts(1,1,1,0), 4'b1000);
        vecs[8] = mkVec(4'b0000, 4'b0000, 0, 2'd0, 1, 4'b0000, 4'b0000, cnts(1,1,1,0), 4'b0000);

        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k]);
            #1;
            checkOutput($sformatf("vec%0d_m_sq_valid", k), 32'(m_sq_valid), 32'(vecs[k].expMv));
            checkOutput($sformatf("vec%0d_s_sq_ready", k), 32'(s_sq_ready), 32'(vecs[k].expSr));
            tick();
            checkOutput($sformatf("vec%0d_outstanding", k), 32'(outstanding), 32'(vecs[k].expCnt));
            checkOutput($sformatf("vec%0d_err_underflow", k), 32'(err_underflow), 32'(vecs[k].expUf));
        end

        // Credit fill on region 1, then one completion re-opens it
        doReset();
        fires = 0;
        s_sq_valid = 4'b0010;
        m_sq_ready = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (s_sq_ready[1]) fires++;
            tick();
        end
        #1;
        checkOutput("fill_fires", 32'(fires), 16);
        checkOutput("fill_full1", 32'(full[1]), 1);
        checkOutput("fill_ready1", 32'(s_sq_ready[1]), 0);
        checkOutput("fill_count1", 32'(outstanding[9:5]), 16);
        s_cq_valid = 1'b1;
        s_cq_vfid  = 2'd1;
        tick();
        s_cq_valid = 1'b0;
        #1;
        checkOutput("fill_cq_ready_still0", 32'(s_sq_ready[1]), 0);
        tick();
        #1;
        checkOutput("fill_cq_count15", 32'(outstanding[9:5]), 15);
        checkOutput("fill_cq_ready1", 32'(s_sq_ready[1]), 1);
        tick();
        #1;
        checkOutput("fill_refill_count16", 32'(outstanding[9:5]), 16);
        checkOutput("fill_refill_ready0", 32'(s_sq_ready[1]), 0);

        // Fire and completion on the same edge cancel, at count 3 and at count 0
        doReset();
        s_sq_valid = 4'b0001;
        m_sq_ready = 4'b0001;
        tick(); tick(); tick();
        s_sq_valid = 4'b0000;
        checkOutput("simul_pre_count3", 32'(outstanding[4:0]), 3);
        s_cq_valid = 1'b1;
        s_cq_vfid  = 2'd0;
        tick();
        s_cq_valid = 1'b0;
        s_sq_valid = 4'b0001;
        tick();
        s_sq_valid = 4'b0000;
        #1;
        checkOutput("simul_count3", 32'(outstanding[4:0]), 3);
        s_cq_valid = 1'b1;
        tick(); tick(); tick();
        s_cq_valid = 1'b0;
        tick();
        checkOutput("simul_drained", 32'(outstanding[4:0]), 0);
        s_cq_valid = 1'b1;
        tick();
        s_cq_valid = 1'b0;
        s_sq_valid = 4'b0001;
        tick();
        s_sq_valid = 4'b0000;
        #1;
        checkOutput("simul_count0", 32'(outstanding[4:0]), 0);
        checkOutput("simul_no_underflow", 32'(err_underflow), 0);

        // Underflow, clear, and clear racing a new underflow
        doReset();
        s_cq_valid = 1'b1;
        s_cq_vfid  = 2'd2;
        tick();
        s_cq_valid = 1'b0;
        tick();
        checkOutput("uf_set", 32'(err_underflow), 32'h4);
        checkOutput("uf_count2", 32'(outstanding[14:10]), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("uf_cleared", 32'(err_underflow), 0);
        s_cq_valid = 1'b1;
        tick();
        s_cq_valid = 1'b0;
        clr_err    = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("uf_set_wins", 32'(err_underflow), 32'h4);

        // Timeout on region 3 after 100 idle cycles
        doReset();
        s_sq_valid = 4'b1000;
        m_sq_ready = 4'b1000;
        tick();
        s_sq_valid = 4'b0000;
        for (int c = 0; c < 99; c++) tick();
        checkOutput("to_not_yet", 32'(err_timeout), 0);
        tick();
        checkOutput("to_set", 32'(err_timeout), 32'h8);
        checkOutput("to_count_kept", 32'(outstanding[19:15]), 1);

        // A completion landing just in time keeps the flag clear
        doReset();
        s_sq_valid = 4'b1000;
        m_sq_ready = 4'b1000;
        tick();
        s_sq_valid = 4'b0000;
        for (int c = 0; c < 98; c++) tick();
        s_cq_valid = 1'b1;
        s_cq_vfid  = 2'd3;
        tick();
        s_cq_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        checkOutput("to_avoided", 32'(err_timeout), 0);
        checkOutput("to_avoided_count", 32'(outstanding[19:15]), 0);

        // Out-of-range vfid on the three-region instance
        b_s_sq_valid = 3'b001;
        b_m_sq_ready = 3'b001;
        tick();
        b_s_sq_valid = 3'b000;
        b_s_cq_valid = 1'b1;
        b_s_cq_vfid  = 2'd3;
        tick();
        b_s_cq_valid = 1'b0;
        tick();
        checkOutput("vfid_set", 32'(b_err_vfid), 1);
        checkOutput("vfid_counts", 32'(b_outstanding), 1);
        checkOutput("vfid_no_underflow", 32'(b_err_underflow), 0);
        b_clr_err = 1'b1;
        tick();
        b_clr_err = 1'b0;
        checkOutput("vfid_cleared", 32'(b_err_vfid), 0);

        // Reset in the middle of traffic with counts 5/2/0/16
        doReset();
        s_sq_valid = 4'b1011;
        m_sq_ready = 4'b1011;
        s_cq_valid = 1'b1;
        s_cq_vfid  = 2'd2;
        tick();
        s_cq_valid = 1'b0;
        tick();
        s_sq_valid = 4'b1001;
        m_sq_ready = 4'b1001;
        tick(); tick(); tick();
        s_sq_valid = 4'b1000;
        m_sq_ready = 4'b1000;
        for (int c = 0; c < 11; c++) tick();
        s_sq_valid = 4'b0000;
        checkOutput("mid_counts", 32'(outstanding), 32'(cnts(5, 2, 0, 16)));
        checkOutput("mid_full", 32'(full), 32'h8);
        checkOutput("mid_uf", 32'(err_underflow), 32'h4);
        areset     = 1'b1;
        s_sq_valid = 4'b1111;
        m_sq_ready = 4'b1111;
        s_cq_valid = 1'b1;
        s_cq_vfid  = 2'd3;
        tick();
        areset     = 1'b0;
        s_sq_valid = 4'b0000;
        s_cq_valid = 1'b0;
        #1;
        checkOutput("mid_rst_counts", 32'(outstanding), 0);
        checkOutput("mid_rst_idle", 32'(idle), 1);
        checkOutput("mid_rst_full", 32'(full), 0);
        checkOutput("mid_rst_errors", 32'({err_underflow, err_timeout, err_vfid}), 0);
        checkOutput("mid_rst_m_sq_valid", 32'(m_sq_valid), 0);
        checkOutput("mid_rst_s_sq_ready", 32'(s_sq_ready), 32'hf);
        m_sq_ready = 4'b0000;
        tick();
        checkOutput("mid_rst_no_stale_dec", 32'(err_underflow), 0);
        s_cq_valid = 1'b1;
        s_cq_vfid  = 2'd0;
        tick();
        s_cq_valid = 1'b0;
        tick();
        checkOutput("mid_stale_cq_uf", 32'(err_underflow), 32'h1);
        checkOutput("mid_stale_cq_count", 32'(outstanding), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/rdma_cq_credit_tracker.md
# rdma_cq_credit_tracker

Per-region outstanding-request tracker on the user side of the RDMA send-queue/completion path. Counts SQ requests each vFPGA region issues toward the network arbiter, retires them on matching CQ entries (tapped from the network completion stream, routed by vfid), and backpressures a region's SQ once its outstanding limit is reached. Also flags completion timeouts and accounting errors per region so host software can detect a stalled or misbehaving queue pair.

## Interface
- N_REGIONS, 4: number of user regions tracked.
- MAX_OUTSTANDING, 16: per-region credit limit, 1..2^CNT_W-1.
- CNT_W, 5: outstanding-counter width.
- TIMEOUT_CYCLES, 65535: idle-completion cycles before timeout, at least 1.
- TO_W, 16: timeout-counter width, 2^TO_W > TIMEOUT_CYCLES.
- VFID_W, 2: clog2(N_REGIONS), minimum 1.

Ports:
- aclk  in  1  single clock; all logic is rising-edge.
- areset  in  1  reset, synchronous and active-high.
- s_sq_valid  in  N_REGIONS  per-region SQ request valid from user.
- s_sq_ready  out  N_REGIONS  per-region SQ ready to user.
- m_sq_valid  out  N_REGIONS  per-region SQ valid toward arbiter.
- m_sq_ready  in  N_REGIONS  per-region SQ ready from arbiter.
- s_cq_valid  in  1  CQ tap valid; one completion per cycle.
- s_cq_vfid  in  VFID_W  region the completion belongs to.
- s_cq_ready  out  1  constant 1; the tap never stalls.
- clr_err  in  1  one-cycle pulse that clears all sticky error bits.
- outstanding  out  N_REGIONS*CNT_W  per-region counts; region i occupies bits [i*CNT_W +: CNT_W].
- full  out  N_REGIONS  per-region count == MAX_OUTSTANDING.
- idle  out  1  all counts zero.
- err_underflow  out  N_REGIONS  sticky: completion arrived for a region with nothing outstanding.
- err_timeout  out  N_REGIONS  sticky: completion timeout.
- err_vfid  out  1  sticky: completion with s_cq_vfid >= N_REGIONS.

## Operation
- SQ gating is combinational per region i:
  - m_sq_valid[i] = s_sq_valid[i] & ~full[i]
  - s_sq_ready[i] = m_sq_ready[i] & ~full[i]
  - fire[i] = s_sq_valid[i] & s_sq_ready[i]
- CQ stage: s_cq_valid and s_cq_vfid are registered once, giving cq_v_q and cq_id_q. dec[i] = cq_v_q & (cq_id_q == i).
- Counter update per region, applied each cycle:
  - fire only: count + 1.
  - dec only, count > 0: count - 1.
  - fire and dec together: count unchanged.
  - dec only, count == 0: count stays 0 and err_underflow[i] is set.
- Counts never exceed MAX_OUTSTANDING; the gating guarantees this.
- Out-of-range vfid: cq_v_q with cq_id_q >= N_REGIONS sets err_vfid. No counter changes.
- Timeout counter per region:
  - Cleared to 0 when count == 0 or dec[i] is asserted.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - When it equals TIMEOUT_CYCLES, err_timeout[i] is set. The count is not modified.
- Sticky errors: clr_err clears all of them. If a set condition occurs in the same cycle as clr_err, set wins.
- Reset, including mid-traffic: all counts, timeout counters, the CQ stage and all error bits go to 0.
  - Outputs after reset: full=0, idle=1, s_cq_ready=1.
  - m_sq_valid and s_sq_ready follow their inputs.
  - Completions for requests issued before reset count as underflow. This is intended.

## Timing
- SQ path has zero latency, purely combinational through the gate. full is registered, so a fire that fills the region deasserts s_sq_ready from the next cycle.
- CQ-to-count latency is 2 edges: the completion is sampled, then the count is updated. outstanding, full and idle reflect the decrement one cycle after cq_v_q.
- With full=1, a completion re-opens the SQ on the cycle after the count update. There is no bubble beyond that.
- err_* bits assert on the edge where their condition is evaluated: one cycle after cq_v_q for underflow and vfid, and on the count-reaching edge for timeout.
- Throughput: one SQ fire per region per cycle, plus one completion per cycle, sustained.

## Test plan
- Credit fill, N_REGIONS=4, MAX=16: region 1 holds s_sq_valid with m_sq_ready=1. Expect exactly 16 fires, then full[1]=1 and s_sq_ready[1]=0. One CQ with vfid 1 restores ready 2 cycles later; outstanding[1] reads 15, then 16.
- Simultaneous events: region 0 at count 3, fire and dec in the same cycle -> count stays 3. At count 0 with the same pair -> count stays 0 and no underflow.
- Underflow and clear: CQ vfid 2 with count 0 -> err_underflow[2]=1 and count 0. clr_err pulse -> bit clears. clr_err in the same cycle as a new underflow -> bit stays 1.
- Timeout, TIMEOUT_CYCLES=100: one fire on region 3 and no CQ -> err_timeout[3] sets exactly 100 cycles after the count becomes 1. A CQ at cycle 99 instead -> no flag.
- Bad vfid with N_REGIONS=3, VFID_W=2: CQ vfid 3 -> err_vfid=1 and all counts unchanged.
- Reset mid-traffic: regions at counts 5/2/0/16, assert areset for 1 cycle -> all counts 0, idle=1, full=0, errors 0. A stale CQ afterwards -> underflow flagged.
